// File: rtl/teras_wb_bridge.sv
// Wishbone slave bridging a host CPU to the teras core through input/output FIFOs.
// Optional pad mirror of core results is enabled by defining TERAS_BRIDGE_IO_MIRROR_EN.
module teras_wb_bridge #(
    parameter int unsigned DATA_W    = 32,
    parameter int unsigned IN_DEPTH  = 4,
    parameter int unsigned OUT_DEPTH = 4,
    parameter int unsigned IO_W      = 24,
    parameter int unsigned IO_LSB    = 8,
    parameter int unsigned PADS      = 38
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              wbs_stb_i,
    input  logic              wbs_cyc_i,
    input  logic              wbs_we_i,
    input  logic [3:0]        wbs_sel_i,
    input  logic [31:0]       wbs_dat_i,
    input  logic [31:0]       wbs_adr_i,
    output logic              wbs_ack_o,
    output logic [31:0]       wbs_dat_o,
    output logic              core_rts_o,
    input  logic              core_rtr_i,
    output logic [DATA_W-1:0] core_data_o,
    input  logic              core_rts_i,
    output logic              core_rtr_o,
    input  logic [DATA_W-1:0] core_data_i,
    output logic [PADS-1:0]   io_out,
    output logic [PADS-1:0]   io_oeb
);

    localparam int unsigned IN_AW  = $clog2(IN_DEPTH);
    localparam int unsigned IN_CW  = IN_AW + 1;
    localparam int unsigned OUT_AW = $clog2(OUT_DEPTH);
    localparam int unsigned OUT_CW = OUT_AW + 1;

    localparam logic [1:0] REG_DATA_IN  = 2'd0;
    localparam logic [1:0] REG_DATA_OUT = 2'd1;
    localparam logic [1:0] REG_STATUS   = 2'd2;
    localparam logic [1:0] REG_CTRL     = 2'd3;

    logic              ack_q, ack_d;
    logic [31:0]       dat_q, dat_d;
    logic              rd_ok_q, rd_ok_d;
    logic              run_q, run_d;
    logic              flush_q, flush_d;
    logic              ovf_q, ovf_d;
    logic              unf_q, unf_d;

    logic [DATA_W-1:0] in_mem_q [IN_DEPTH];
    logic [DATA_W-1:0] in_mem_d [IN_DEPTH];
    logic [IN_AW-1:0]  in_wr_ptr_q, in_wr_ptr_d, in_rd_ptr_q, in_rd_ptr_d;
    logic [IN_CW-1:0]  in_cnt_q, in_cnt_d;

    logic [DATA_W-1:0] out_mem_q [OUT_DEPTH];
    logic [DATA_W-1:0] out_mem_d [OUT_DEPTH];
    logic [OUT_AW-1:0] out_wr_ptr_q, out_wr_ptr_d, out_rd_ptr_q, out_rd_ptr_d;
    logic [OUT_CW-1:0] out_cnt_q, out_cnt_d;

    logic        req, acc, wr_acc, rd_acc;
    logic [1:0]  reg_sel;
    logic        in_full, in_empty, out_full, out_empty;
    logic        in_push_req, in_push, in_pop, ovf_set;
    logic        out_push, out_pop, out_rd_acc, unf_set;
    logic        st_clr, ctrl_wr;
    logic [31:0] status_w, rdata;
    logic        unused_ok;

    assign unused_ok = ^{wbs_sel_i[3:1], wbs_adr_i[31:4], wbs_adr_i[1:0], wbs_dat_i};

    // Request is accepted in one cycle; side effects land in the ack cycle.
    assign req     = wbs_cyc_i & wbs_stb_i & ~ack_q;
    assign acc     = ack_q & wbs_cyc_i & wbs_stb_i;
    assign wr_acc  = acc & wbs_we_i;
    assign rd_acc  = acc & ~wbs_we_i;
    assign reg_sel = wbs_adr_i[3:2];

    assign in_full   = (in_cnt_q == IN_CW'(IN_DEPTH));
    assign in_empty  = (in_cnt_q == '0);
    assign out_full  = (out_cnt_q == OUT_CW'(OUT_DEPTH));
    assign out_empty = (out_cnt_q == '0);

    assign core_rts_o  = ~in_empty & run_q;
    assign core_data_o = in_mem_q[in_rd_ptr_q];
    assign core_rtr_o  = ~out_full;

    assign in_pop      = core_rts_o & core_rtr_i & ~flush_q;
    assign in_push_req = wr_acc & (reg_sel == REG_DATA_IN);
    assign in_push     = in_push_req & (~in_full | in_pop) & ~flush_q;
    assign ovf_set     = in_push_req & in_full & ~in_pop;

    assign out_push    = core_rts_i & core_rtr_o & ~flush_q;
    assign out_rd_acc  = rd_acc & (reg_sel == REG_DATA_OUT);
    assign out_pop     = out_rd_acc & rd_ok_q;
    assign unf_set     = out_rd_acc & ~rd_ok_q;

    assign st_clr  = wr_acc & (reg_sel == REG_STATUS) & wbs_sel_i[0];
    assign ctrl_wr = wr_acc & (reg_sel == REG_CTRL) & wbs_sel_i[0];

    assign wbs_ack_o = ack_q;
    assign wbs_dat_o = dat_q;

    always_comb begin
        status_w        = '0;
        status_w[0]     = in_full;
        status_w[1]     = in_empty;
        status_w[2]     = out_full;
        status_w[3]     = out_empty;
        status_w[4]     = ovf_q;
        status_w[5]     = unf_q;
        status_w[15:8]  = 8'(in_cnt_q);
        status_w[23:16] = 8'(out_cnt_q);
    end

    // Read data is captured at request time; a pending flush makes DATA_OUT look empty.
    always_comb begin
        rdata = '0;
        unique case (reg_sel)
            REG_DATA_OUT: rdata = (out_empty | flush_q) ? 32'd0 : 32'(out_mem_q[out_rd_ptr_q]);
            REG_STATUS:   rdata = status_w;
            REG_CTRL:     rdata = {30'd0, run_q, flush_q};
            default:      rdata = '0;
        endcase
    end

    always_comb begin
        in_mem_d    = in_mem_q;
        in_wr_ptr_d = in_wr_ptr_q;
        in_rd_ptr_d = in_rd_ptr_q;
        in_cnt_d    = in_cnt_q;
        if (flush_q) begin
            in_wr_ptr_d = '0;
            in_rd_ptr_d = '0;
            in_cnt_d    = '0;
        end else begin
            if (in_push) begin
                in_mem_d[in_wr_ptr_q] = DATA_W'(wbs_dat_i);
                in_wr_ptr_d           = in_wr_ptr_q + IN_AW'(1);
            end
            if (in_pop) begin
                in_rd_ptr_d = in_rd_ptr_q + IN_AW'(1);
            end
            unique case ({in_push, in_pop})
                2'b10:   in_cnt_d = in_cnt_q + IN_CW'(1);
                2'b01:   in_cnt_d = in_cnt_q - IN_CW'(1);
                default: in_cnt_d = in_cnt_q;
            endcase
        end
    end

    always_comb begin
        out_mem_d    = out_mem_q;
        out_wr_ptr_d = out_wr_ptr_q;
        out_rd_ptr_d = out_rd_ptr_q;
        out_cnt_d    = out_cnt_q;
        if (flush_q) begin
            out_wr_ptr_d = '0;
            out_rd_ptr_d = '0;
            out_cnt_d    = '0;
        end else begin
            if (out_push) begin
                out_mem_d[out_wr_ptr_q] = core_data_i;
                out_wr_ptr_d            = out_wr_ptr_q + OUT_AW'(1);
            end
            if (out_pop) begin
                out_rd_ptr_d = out_rd_ptr_q + OUT_AW'(1);
            end
            unique case ({out_push, out_pop})
                2'b10:   out_cnt_d = out_cnt_q + OUT_CW'(1);
                2'b01:   out_cnt_d = out_cnt_q - OUT_CW'(1);
                default: out_cnt_d = out_cnt_q;
            endcase
        end
    end

    // Status sticky bits: set wins over W1C, flush clears everything.
    always_comb begin
        ack_d   = req;
        dat_d   = '0;
        rd_ok_d = rd_ok_q;
        run_d   = run_q;
        flush_d = 1'b0;
        if (req & ~wbs_we_i) begin
            dat_d   = rdata;
            rd_ok_d = ~out_empty & ~flush_q;
        end
        if (ctrl_wr) begin
            run_d   = wbs_dat_i[1];
            flush_d = wbs_dat_i[0];
        end
        if (flush_q) begin
            ovf_d = 1'b0;
            unf_d = 1'b0;
        end else begin
            ovf_d = (ovf_q & ~(st_clr & wbs_dat_i[4])) | ovf_set;
            unf_d = (unf_q & ~(st_clr & wbs_dat_i[5])) | unf_set;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ack_q        <= 1'b0;
            dat_q        <= '0;
            rd_ok_q      <= 1'b0;
            run_q        <= 1'b1;
            flush_q      <= 1'b0;
            ovf_q        <= 1'b0;
            unf_q        <= 1'b0;
            in_mem_q     <= '{default: '0};
            in_wr_ptr_q  <= '0;
            in_rd_ptr_q  <= '0;
            in_cnt_q     <= '0;
            out_mem_q    <= '{default: '0};
            out_wr_ptr_q <= '0;
            out_rd_ptr_q <= '0;
            out_cnt_q    <= '0;
        end else begin
            ack_q        <= ack_d;
            dat_q        <= dat_d;
            rd_ok_q      <= rd_ok_d;
            run_q        <= run_d;
            flush_q      <= flush_d;
            ovf_q        <= ovf_d;
            unf_q        <= unf_d;
            in_mem_q     <= in_mem_d;
            in_wr_ptr_q  <= in_wr_ptr_d;
            in_rd_ptr_q  <= in_rd_ptr_d;
            in_cnt_q     <= in_cnt_d;
            out_mem_q    <= out_mem_d;
            out_wr_ptr_q <= out_wr_ptr_d;
            out_rd_ptr_q <= out_rd_ptr_d;
            out_cnt_q    <= out_cnt_d;
        end
    end

`ifdef TERAS_BRIDGE_IO_MIRROR_EN
    logic [IO_W-1:0] mirror_q, mirror_d;
    logic            strobe_q, strobe_d;

    // Latest pushed result held on pads, with a one-cycle strobe per push.
    always_comb begin
        mirror_d = mirror_q;
        strobe_d = out_push;
        if (out_push) begin
            mirror_d = core_data_i[IO_W-1:0];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mirror_q <= '0;
            strobe_q <= 1'b0;
        end else begin
            mirror_q <= mirror_d;
            strobe_q <= strobe_d;
        end
    end

    always_comb begin
        io_out                     = '0;
        io_out[IO_LSB +: IO_W]     = mirror_q;
        io_out[IO_LSB + IO_W]      = strobe_q;
        io_oeb                     = '1;
        io_oeb[IO_LSB +: IO_W + 1] = '0;
    end
`else
    assign io_out = '0;
    assign io_oeb = '1;
`endif

endmodule

// File: tb/tb_teras_wb_bridge.sv
// Directed self-checking bench for teras_wb_bridge (default parameters).
module tb_teras_wb_bridge;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        wbs_stb_i, wbs_cyc_i, wbs_we_i;
    logic [3:0]  wbs_sel_i;
    logic [31:0] wbs_dat_i, wbs_adr_i;
    logic        wbs_ack_o;
    logic [31:0] wbs_dat_o;
    logic        core_rts_o, core_rtr_i;
    logic [31:0] core_data_o;
    logic        core_rts_i, core_rtr_o;
    logic [31:0] core_data_i;
    logic [37:0] io_out, io_oeb;

    int checks   = 0;
    int failures = 0;

    localparam logic [31:0] A_DIN  = 32'h0;
    localparam logic [31:0] A_DOUT = 32'h4;
    localparam logic [31:0] A_STAT = 32'h8;
    localparam logic [31:0] A_CTRL = 32'hC;

    teras_wb_bridge dut (
        .clk(clk), .rst_n(rst_n),
        .wbs_stb_i(wbs_stb_i), .wbs_cyc_i(wbs_cyc_i), .wbs_we_i(wbs_we_i),
        .wbs_sel_i(wbs_sel_i), .wbs_dat_i(wbs_dat_i), .wbs_adr_i(wbs_adr_i),
        .wbs_ack_o(wbs_ack_o), .wbs_dat_o(wbs_dat_o),
        .core_rts_o(core_rts_o), .core_rtr_i(core_rtr_i), .core_data_o(core_data_o),
        .core_rts_i(core_rts_i), .core_rtr_o(core_rtr_o), .core_data_i(core_data_i),
        .io_out(io_out), .io_oeb(io_oeb)
    );

    always #5 clk = ~clk;

    task automatic wait_ack();
        bit got = 0;
        for (int i = 0; i < 8; i++) begin
            @(posedge clk); #1;
            if (wbs_ack_o) begin got = 1; break; end
        end
        checks++;
        if (!got) begin failures++; $display("FAIL wb_ack_timeout got 0 want 1"); end
    endtask

    task automatic wb_write(input logic [31:0] adr, input logic [31:0] dat, input logic [3:0] sel);
        @(posedge clk); #1;
        wbs_cyc_i = 1; wbs_stb_i = 1; wbs_we_i = 1; wbs_adr_i = adr; wbs_dat_i = dat; wbs_sel_i = sel;
        wait_ack();
        @(posedge clk); #1;
        wbs_cyc_i = 0; wbs_stb_i = 0; wbs_we_i = 0;
    endtask

    task automatic wb_read(input logic [31:0] adr, output logic [31:0] dat);
        @(posedge clk); #1;
        wbs_cyc_i = 1; wbs_stb_i = 1; wbs_we_i = 0; wbs_adr_i = adr; wbs_sel_i = 4'hF;
        wait_ack();
        dat = wbs_dat_o;
        @(posedge clk); #1;
        wbs_cyc_i = 0; wbs_stb_i = 0;
    endtask

    task automatic test_reset();
        logic [31:0] d;
        rst_n = 0; wbs_cyc_i = 0; wbs_stb_i = 0; wbs_we_i = 0; wbs_sel_i = 0;
        wbs_dat_i = 0; wbs_adr_i = 0; core_rtr_i = 0; core_rts_i = 0; core_data_i = 0;
        repeat (3) @(posedge clk);
        #1 rst_n = 1;
        checks++; if (wbs_ack_o !== 1'b0) begin failures++; $display("FAIL rst_ack got %b want 0", wbs_ack_o); end
        checks++; if (wbs_dat_o !== 32'h0) begin failures++; $display("FAIL rst_dat got %h want 0", wbs_dat_o); end
        checks++; if (core_rts_o !== 1'b0) begin failures++; $display("FAIL rst_rts got %b want 0", core_rts_o); end
        checks++; if (core_rtr_o !== 1'b1) begin failures++; $display("FAIL rst_rtr got %b want 1", core_rtr_o); end
        checks++; if (io_out !== 38'h0) begin failures++; $display("FAIL rst_io_out got %h want 0", io_out); end
        wb_read(A_STAT, d);
        checks++; if (d !== 32'h0000000A) begin failures++; $display("FAIL rst_status got %h want 0000000a", d); end
        // Ack must be a single-cycle pulse.
        checks++; if (wbs_ack_o !== 1'b0) begin failures++; $display("FAIL ack_pulse got %b want 0", wbs_ack_o); end
        wb_read(A_CTRL, d);
        checks++; if (d !== 32'h2) begin failures++; $display("FAIL rst_ctrl got %h want 2", d); end
    endtask

    task automatic test_fill_ovf();
        logic [31:0] d;
        core_rtr_i = 0;
        for (int i = 1; i <= 4; i++) wb_write(A_DIN, 32'h11 * i, 4'h0);
        wb_read(A_STAT, d);
        checks++; if (d !== 32'h00000409) begin failures++; $display("FAIL fill_status got %h want 00000409", d); end
        wb_write(A_DIN, 32'h55, 4'hF);
        wb_read(A_STAT, d);
        checks++; if (d !== 32'h00000419) begin failures++; $display("FAIL ovf_status got %h want 00000419", d); end
        checks++; if (core_data_o !== 32'h11) begin failures++; $display("FAIL ovf_head got %h want 11", core_data_o); end
    endtask

    task automatic test_drain();
        logic [31:0] exp [4];
        logic [31:0] d;
        exp = '{32'h11, 32'h22, 32'h33, 32'h44};
        core_rtr_i = 1;
        for (int i = 0; i < 4; i++) begin
            checks++; if (core_rts_o !== 1'b1 || core_data_o !== exp[i]) begin
                failures++; $display("FAIL drain_%0d got rts=%b data=%h want rts=1 data=%h", i, core_rts_o, core_data_o, exp[i]);
            end
            @(posedge clk); #1;
        end
        checks++; if (core_rts_o !== 1'b0) begin failures++; $display("FAIL drain_end_rts got %b want 0", core_rts_o); end
        core_rtr_i = 0;
        wb_read(A_STAT, d);
        checks++; if (d !== 32'h0000001A) begin failures++; $display("FAIL drain_status got %h want 0000001a", d); end
        wb_write(A_STAT, 32'h10, 4'b0010);
        wb_read(A_STAT, d);
        checks++; if (d !== 32'h0000001A) begin failures++; $display("FAIL w1c_nosel got %h want 0000001a", d); end
        wb_write(A_STAT, 32'h10, 4'b0001);
        wb_read(A_STAT, d);
        checks++; if (d !== 32'h0000000A) begin failures++; $display("FAIL w1c_ovf got %h want 0000000a", d); end
    endtask

    task automatic test_result();
        logic [31:0] d;
        checks++; if (core_rtr_o !== 1'b1) begin failures++; $display("FAIL res_rtr got %b want 1", core_rtr_o); end
        core_rts_i = 1; core_data_i = 32'hCAFEBABE;
        @(posedge clk); #1;
        core_rts_i = 0;
`ifndef TERAS_BRIDGE_IO_MIRROR_EN
        checks++; if (io_out !== 38'h0 || io_oeb !== 38'h3F_FFFF_FFFF) begin
            failures++; $display("FAIL io_default got out=%h oeb=%h want out=0 oeb=3fffffffff", io_out, io_oeb);
        end
`endif
        wb_read(A_STAT, d);
        checks++; if (d !== 32'h00010002) begin failures++; $display("FAIL res_status got %h want 00010002", d); end
        wb_read(A_DOUT, d);
        checks++; if (d !== 32'hCAFEBABE) begin failures++; $display("FAIL res_read got %h want cafebabe", d); end
        wb_read(A_DOUT, d);
        checks++; if (d !== 32'h0) begin failures++; $display("FAIL unf_read got %h want 0", d); end
        wb_read(A_STAT, d);
        checks++; if (d !== 32'h0000002A) begin failures++; $display("FAIL unf_status got %h want 0000002a", d); end
        wb_write(A_STAT, 32'h30, 4'h1);
        wb_read(A_STAT, d);
        checks++; if (d !== 32'h0000000A) begin failures++; $display("FAIL w1c_both got %h want 0000000a", d); end
    endtask

    task automatic test_mirror();
`ifdef TERAS_BRIDGE_IO_MIRROR_EN
        logic [31:0] d;
        core_rts_i = 1; core_data_i = 32'h00ABCDEF;
        @(posedge clk); #1;
        core_rts_i = 0;
        checks++; if (io_out[31:8] !== 24'hABCDEF || io_out[32] !== 1'b1) begin
            failures++; $display("FAIL mirror_val got %h want field=abcdef strobe=1", io_out);
        end
        checks++; if (io_oeb !== 38'h3E_0000_00FF) begin failures++; $display("FAIL mirror_oeb got %h want 3e000000ff", io_oeb); end
        @(posedge clk); #1;
        checks++; if (io_out !== 38'h00_ABCD_EF00) begin failures++; $display("FAIL mirror_hold got %h want 00abcdef00", io_out); end
        wb_read(A_DOUT, d);
        checks++; if (d !== 32'h00ABCDEF) begin failures++; $display("FAIL mirror_read got %h want 00abcdef", d); end
`endif
    endtask

    task automatic test_back_to_back();
        logic [31:0] d;
        core_rts_i = 1;
        for (int i = 0; i < 4; i++) begin
            core_data_i = 32'hA0 + i;
            @(posedge clk); #1;
        end
        core_data_i = 32'hA4;
        checks++; if (core_rtr_o !== 1'b0) begin failures++; $display("FAIL full_rtr got %b want 0", core_rtr_o); end
        wbs_cyc_i = 1; wbs_stb_i = 1; wbs_we_i = 0; wbs_adr_i = A_DOUT;
        @(posedge clk); #1;
        checks++; if (wbs_ack_o !== 1'b1 || wbs_dat_o !== 32'hA0) begin
            failures++; $display("FAIL simul_read got ack=%b dat=%h want ack=1 dat=a0", wbs_ack_o, wbs_dat_o);
        end
        checks++; if (core_rtr_o !== 1'b0) begin failures++; $display("FAIL simul_rtr got %b want 0", core_rtr_o); end
        @(posedge clk); #1;
        wbs_cyc_i = 0; wbs_stb_i = 0;
        checks++; if (core_rtr_o !== 1'b1) begin failures++; $display("FAIL after_pop_rtr got %b want 1", core_rtr_o); end
        @(posedge clk); #1;
        core_rts_i = 0;
        checks++; if (core_rtr_o !== 1'b0) begin failures++; $display("FAIL refill_rtr got %b want 0", core_rtr_o); end
        wb_read(A_STAT, d);
        checks++; if (d !== 32'h00040006) begin failures++; $display("FAIL refill_status got %h want 00040006", d); end
        for (int i = 1; i <= 4; i++) begin
            wb_read(A_DOUT, d);
            checks++; if (d !== 32'hA0 + i) begin failures++; $display("FAIL wrap_read_%0d got %h want %h", i, d, 32'hA0 + i); end
        end
    endtask

    task automatic test_flush_ctrl();
        logic [31:0] d;
        core_rtr_i = 0;
        wb_write(A_DIN, 32'h77, 4'hF);
        wb_write(A_DIN, 32'h88, 4'hF);
        @(posedge clk); #1;
        core_rts_i = 1; core_data_i = 32'h99;
        @(posedge clk); #1;
        core_rts_i = 0;
        wb_read(A_STAT, d);
        checks++; if (d !== 32'h00010200) begin failures++; $display("FAIL preflush_status got %h want 00010200", d); end
        wb_write(A_CTRL, 32'h3, 4'h1);
        wb_read(A_STAT, d);
        checks++; if (d !== 32'h0000000A) begin failures++; $display("FAIL flush_status got %h want 0000000a", d); end
        wb_read(A_CTRL, d);
        checks++; if (d !== 32'h2) begin failures++; $display("FAIL flush_ctrl got %h want 2", d); end
        wb_write(A_CTRL, 32'h0, 4'b1110);
        wb_read(A_CTRL, d);
        checks++; if (d !== 32'h2) begin failures++; $display("FAIL ctrl_nosel got %h want 2", d); end
        wb_write(A_CTRL, 32'h0, 4'h1);
        core_rtr_i = 1;
        wb_write(A_DIN, 32'h5A, 4'hF);
        checks++; if (core_rts_o !== 1'b0) begin failures++; $display("FAIL stopped_rts got %b want 0", core_rts_o); end
        wb_read(A_STAT, d);
        checks++; if (d !== 32'h00000108) begin failures++; $display("FAIL stopped_status got %h want 00000108", d); end
        wb_write(A_CTRL, 32'h2, 4'h1);
        checks++; if (core_rts_o !== 1'b1 || core_data_o !== 32'h5A) begin
            failures++; $display("FAIL run_rts got rts=%b data=%h want rts=1 data=5a", core_rts_o, core_data_o);
        end
        @(posedge clk); #1;
        core_rtr_i = 0;
        wb_read(A_STAT, d);
        checks++; if (d !== 32'h0000000A) begin failures++; $display("FAIL run_drain_status got %h want 0000000a", d); end
    endtask

    task automatic test_reset_mid();
        logic [31:0] d;
        bit          stray = 0;
        core_rtr_i = 0;
        for (int i = 1; i <= 3; i++) wb_write(A_DIN, 32'(i), 4'hF);
        @(posedge clk); #1;
        wbs_cyc_i = 1; wbs_stb_i = 1; wbs_we_i = 0; wbs_adr_i = A_STAT;
        @(posedge clk); #2;
        rst_n = 0;
        #1;
        checks++; if (wbs_ack_o !== 1'b0 || wbs_dat_o !== 32'h0) begin
            failures++; $display("FAIL midrst_bus got ack=%b dat=%h want ack=0 dat=0", wbs_ack_o, wbs_dat_o);
        end
        checks++; if (core_rts_o !== 1'b0) begin failures++; $display("FAIL midrst_rts got %b want 0", core_rts_o); end
        @(posedge clk); #1;
        wbs_cyc_i = 0; wbs_stb_i = 0;
        @(posedge clk); #1;
        rst_n = 1;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            if (wbs_ack_o) stray = 1;
        end
        checks++; if (stray) begin failures++; $display("FAIL midrst_stray_ack got 1 want 0"); end
        wb_read(A_STAT, d);
        checks++; if (d !== 32'h0000000A) begin failures++; $display("FAIL midrst_status got %h want 0000000a", d); end
    endtask

    initial begin
        test_reset();
        test_fill_ovf();
        test_drain();
        test_result();
        test_mirror();
        test_back_to_back();
        test_flush_ctrl();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/teras_wb_bridge.md
TERAS_WB_BRIDGE -- requirements
Module: teras_wb_bridge

Interface
REQ-001 SHALL have parameter DATA_W, default 32, meaning data word width on Wishbone and core sides (DATA_W=32 only on WB side; wider core data truncated/zero-extended).
REQ-002 SHALL have parameter IN_DEPTH, default 4, meaning input FIFO entries (power of two, >=2).
REQ-003 SHALL have parameter OUT_DEPTH, default 4, meaning output FIFO entries (power of two, >=2).
REQ-004 SHALL have parameter IO_W, default 24, meaning number of core result bits mirrored to pads.
REQ-005 SHALL have parameter IO_LSB, default 8, meaning first pad index of the mirror field.
REQ-006 SHALL have parameter PADS, default 38, meaning pad count.
REQ-007 SHALL have ports: clk in 1 system clock; rst_n in 1 asynchronous active-low reset.
REQ-008 SHALL have ports: wbs_stb_i, wbs_cyc_i, wbs_we_i in 1 each; wbs_sel_i in 4; wbs_dat_i, wbs_adr_i in 32; wbs_ack_o out 1; wbs_dat_o out 32 (Wishbone slave).
REQ-009 SHALL have ports: core_rts_o out 1, core_rtr_i in 1, core_data_o out DATA_W (feed to teras core).
REQ-010 SHALL have ports: core_rts_i in 1, core_rtr_o out 1, core_data_i in DATA_W (results from teras core).
REQ-011 SHALL have ports: io_out out PADS, io_oeb out PADS.

Function
REQ-012 SHALL decode register by wbs_adr_i[3:2]: 0 DATA_IN (W), 1 DATA_OUT (R), 2 STATUS (R, W1C), 3 CTRL (R/W); other address bits ignored.
REQ-013 SHALL assert wbs_ack_o for exactly one cycle, registered, the cycle after wbs_cyc_i&wbs_stb_i&!wbs_ack_o; every access acks (latency 1, no stall).
REQ-014 SHALL perform register side effects only in the cycle wbs_ack_o is high.
REQ-015 SHALL push wbs_dat_i into input FIFO on DATA_IN write; if full and no pop that cycle, data dropped and STATUS.ovf set.
REQ-016 SHALL drive core_rts_o = !in_empty & CTRL.run, core_data_o = FIFO head; pop on core_rts_o&core_rtr_i.
REQ-017 SHALL drive core_rtr_o = !out_full; push core_data_i on core_rts_i&core_rtr_o.
REQ-018 SHALL return output FIFO head on DATA_OUT read and pop it; read when empty returns 0 and sets STATUS.unf.
REQ-019 SHALL accept simultaneous push and pop on either FIFO (count unchanged, including full/empty cases).
REQ-020 SHALL report STATUS: [0] in_full, [1] in_empty, [2] out_full, [3] out_empty, [4] ovf, [5] unf, [15:8] in_count, [23:16] out_count, others 0.
REQ-021 SHALL clear ovf/unf when STATUS written with corresponding bit 1 (wbs_sel_i[0] high); set wins over clear in same cycle.
REQ-022 SHALL implement CTRL: bit0 flush (write-1, self-clearing, empties both FIFOs and clears ovf/unf next cycle), bit1 run (read/write); flush takes priority over same-cycle pushes/pops.
REQ-023 SHALL honour wbs_sel_i[0] for CTRL writes; FIFO pushes ignore wbs_sel_i.
REQ-024 SHALL wrap FIFO pointers modulo depth with no lost or duplicated entries.

Reset
REQ-025 SHALL on rst_n low asynchronously: empty both FIFOs, wbs_ack_o=0, wbs_dat_o=0, ovf=unf=0, CTRL.run=1, io mirror register 0, strobe 0.
REQ-026 SHALL drop any in-flight Wishbone access on reset (no ack issued after release for it).

Configuration
REQ-027 SHALL with TERAS_BRIDGE_IO_MIRROR_EN defined: register core_data_i[IO_W-1:0] onto io_out[IO_LSB+:IO_W] on each output-FIFO push, pulse io_out[IO_LSB+IO_W] one cycle with it, io_oeb=0 on those IO_W+1 pads, all other io_out=0, io_oeb=1.
REQ-028 SHALL without TERAS_BRIDGE_IO_MIRROR_EN: io_out all 0, io_oeb all 1, no mirror registers.

Verification
REQ-029 SHALL cover: 4 writes 0x11..0x44 to DATA_IN with core_rtr_i=0 -> STATUS in_full=1, in_count=4; 5th write -> ovf=1, FIFO unchanged.
REQ-030 SHALL cover: core_rtr_i=1, run=1 -> core_data_o sequence 0x11,0x22,0x33,0x44, then core_rts_o=0.
REQ-031 SHALL cover: core returns 0xCAFEBABE -> DATA_OUT read gives 0xCAFEBABE, next read gives 0 and unf=1; W1C 0x30 clears both.
REQ-032 SHALL cover: out FIFO full, core_rts_i=1 and DATA_OUT read same cycle -> core_rtr_o stays 0 that cycle, then 1, count returns to 4 after next push.
REQ-033 SHALL cover: mirror enabled, result 0x00ABCDEF -> io_out[31:8]=0xABCDEF, io_out[32] high one cycle.
REQ-034 SHALL cover: rst_n low mid-access with 3 entries queued -> ack 0, both FIFOs empty, STATUS=0x0000000A after release.
